// File: rtl/iob_indir_mp.sv
// iob_indir_mp: multi-read-port indirect I/O buffer with per-entry ready bits, flush and ready count
module iob_indir_mp #(
  parameter int ADDR_WIDTH = 6,
  parameter int ADDR_COUNT = 64,
  parameter int DATA_WIDTH = 65,
  parameter int RD_PORTS   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [RD_PORTS-1:0]              read_clkEn,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0]   read_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0]   read_data,
  output logic [RD_PORTS-1:0]              read_ready,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             write_wen,
  input  logic [ADDR_WIDTH-1:0]            writeI_addr,
  input  logic                             writeI_ready,
  input  logic                             writeI_wen,
  input  logic                             flush,
  output logic [ADDR_WIDTH:0]              ready_cnt
);
  localparam logic [ADDR_WIDTH:0] LP_LIM = (ADDR_WIDTH+1)'(ADDR_COUNT);
  logic [DATA_WIDTH-1:0] r_ram [ADDR_COUNT];
  logic [ADDR_COUNT-1:0] r_rdy, w_rdy_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr [RD_PORTS];
  logic [ADDR_WIDTH:0]   r_cnt, w_cnt;
  logic                  w_wr_ok, w_wi_ok;
  assign w_wr_ok   = write_wen && ({1'b0, write_addr} < LP_LIM);
  assign w_wi_ok   = writeI_wen && ({1'b0, writeI_addr} < LP_LIM);
  assign ready_cnt = r_cnt;
  // flush < data write < indirect write; count taken from next state so it never lags
  always_comb begin
    w_rdy_nxt = flush ? '0 : r_rdy;
    if (w_wr_ok) w_rdy_nxt[write_addr] = 1'b1;
    if (w_wi_ok) w_rdy_nxt[writeI_addr] = writeI_ready;
    w_cnt = '0;
    for (int i = 0; i < ADDR_COUNT; i++) w_cnt = w_cnt + (ADDR_WIDTH+1)'(w_rdy_nxt[i]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy <= '0;
      r_cnt <= '0;
      for (int p = 0; p < RD_PORTS; p++) r_raddr[p] <= '0;
    end else begin
      r_rdy <= w_rdy_nxt;
      r_cnt <= w_cnt;
      for (int p = 0; p < RD_PORTS; p++)
        if (read_clkEn[p]) r_raddr[p] <= read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_ram[write_addr] <= write_data;
  end
  genvar g;
  for (g = 0; g < RD_PORTS; g++) begin : g_rd
    logic w_ok;
    assign w_ok = {1'b0, r_raddr[g]} < LP_LIM;
    assign read_data[g*DATA_WIDTH +: DATA_WIDTH] = w_ok ? r_ram[r_raddr[g]] : '0;
    assign read_ready[g] = w_ok && r_rdy[r_raddr[g]];
  end
endmodule

// File: tb/tb_iob_indir_mp.sv
// tb_iob_indir_mp: randomized + directed scoreboard bench against an array-based reference model
module tb_iob_indir_mp;
  logic        clk = 0;
  logic        rst = 0;
  logic [1:0]  read_clkEn = '0;
  logic [11:0] read_addr = '0;
  logic [129:0] read_data;
  logic [1:0]  read_ready;
  logic [5:0]  write_addr = '0;
  logic [64:0] write_data = '0;
  logic        write_wen = 0;
  logic [5:0]  writeI_addr = '0;
  logic        writeI_ready = 0;
  logic        writeI_wen = 0;
  logic        flush = 0;
  logic [6:0]  ready_cnt;
  logic [64:0] read_data48;
  logic        read_ready48;
  logic [6:0]  ready_cnt48;

  iob_indir_mp dut (
    .clk(clk), .rst(rst), .read_clkEn(read_clkEn), .read_addr(read_addr),
    .read_data(read_data), .read_ready(read_ready), .write_addr(write_addr),
    .write_data(write_data), .write_wen(write_wen), .writeI_addr(writeI_addr),
    .writeI_ready(writeI_ready), .writeI_wen(writeI_wen), .flush(flush),
    .ready_cnt(ready_cnt));

  iob_indir_mp #(.ADDR_COUNT(48), .RD_PORTS(1)) dut48 (
    .clk(clk), .rst(rst), .read_clkEn(read_clkEn[0]), .read_addr(read_addr[5:0]),
    .read_data(read_data48), .read_ready(read_ready48), .write_addr(write_addr),
    .write_data(write_data), .write_wen(write_wen), .writeI_addr(writeI_addr),
    .writeI_ready(writeI_ready), .writeI_wen(writeI_wen), .flush(flush),
    .ready_cnt(ready_cnt48));

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  cnt, cnt48;
    logic [1:0]  rdy, dk;
    logic [64:0] d0, d1, d48;
    logic        r48, dk48;
  } exp_t;
  exp_t q[$];

  bit          m_rdy [64];
  bit          m_wr [64];
  logic [64:0] m_ram [64];
  int          m_addr [2];
  int          errors = 0, checks = 0;

  task automatic chk(input string n, input logic [64:0] a, input logic [64:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic idle();
    read_clkEn = '0; write_wen = 0; writeI_wen = 0; flush = 0;
  endtask

  // one clock: apply the reference rules in precedence order, then queue the expected view
  task automatic cycle();
    exp_t e;
    int c;
    @(posedge clk);
    for (int p = 0; p < 2; p++) if (read_clkEn[p]) m_addr[p] = int'(read_addr[p*6 +: 6]);
    if (flush) for (int a = 0; a < 64; a++) m_rdy[a] = 0;
    if (write_wen) begin
      m_ram[write_addr] = write_data; m_wr[write_addr] = 1; m_rdy[write_addr] = 1;
    end
    if (writeI_wen) m_rdy[writeI_addr] = writeI_ready;
    c = 0;
    for (int a = 0; a < 48; a++) c += int'(m_rdy[a]);
    e.cnt48 = 7'(c);
    for (int a = 48; a < 64; a++) c += int'(m_rdy[a]);
    e.cnt = 7'(c);
    e.rdy = {m_rdy[m_addr[1]], m_rdy[m_addr[0]]};
    e.dk  = {m_wr[m_addr[1]], m_wr[m_addr[0]]};
    e.d0  = m_ram[m_addr[0]];
    e.d1  = m_ram[m_addr[1]];
    e.r48 = m_addr[0] < 48 && m_rdy[m_addr[0]];
    e.dk48 = m_addr[0] < 48 && m_wr[m_addr[0]];
    e.d48 = m_ram[m_addr[0]];
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ready_cnt", 65'(ready_cnt), 65'(e.cnt));
      chk("ready_cnt48", 65'(ready_cnt48), 65'(e.cnt48));
      chk("read_ready", 65'(read_ready), 65'(e.rdy));
      chk("read_ready48", 65'(read_ready48), 65'(e.r48));
      if (e.dk[0]) chk("read_data0", read_data[64:0], e.d0);
      if (e.dk[1]) chk("read_data1", read_data[129:65], e.d1);
      if (e.dk48) chk("read_data48", read_data48, e.d48);
    end
  end

  task automatic wr(input int a, input logic [64:0] d);
    idle(); write_wen = 1; write_addr = 6'(a); write_data = d; cycle();
  endtask

  task automatic wi(input int a, input bit r);
    idle(); writeI_wen = 1; writeI_addr = 6'(a); writeI_ready = r; cycle();
  endtask

  task automatic latch(input bit [1:0] en, input int a);
    idle(); read_clkEn = en; read_addr = {6'(a), 6'(a)}; cycle();
  endtask

  initial begin
    for (int a = 0; a < 64; a++) begin m_rdy[a] = 0; m_wr[a] = 0; m_ram[a] = '0; end
    m_addr[0] = 0; m_addr[1] = 0;
    #2;
    chk("reset_ready", 65'(read_ready), 65'd0);
    chk("reset_cnt", 65'(ready_cnt), 65'd0);
    @(negedge clk); rst = 1;
    wr(5, 65'h1_DEAD_BEEF_0000_0001);
    latch(2'b01, 5);
    latch(2'b11, 5);
    wi(5, 0);
    idle(); write_wen = 1; write_addr = 9; write_data = 65'h0_1234_5678_9ABC_DEF0;
    writeI_wen = 1; writeI_addr = 9; writeI_ready = 0; read_clkEn = 2'b01; read_addr = 12'd9; cycle();
    wr(1, 65'h11); wr(2, 65'h22); wr(3, 65'h33);
    idle(); flush = 1; write_wen = 1; write_addr = 2; write_data = 65'h2222; read_clkEn = 2'b11;
    read_addr = {6'd3, 6'd2}; cycle();
    for (int a = 0; a < 64; a++) wr(a, {$urandom, $urandom, 1'b1});
    wr(63, 65'h63);
    wr(63, 65'h64);
    wi(0, 0);
    latch(2'b01, 50);
    wi(50, 0);
    wr(50, 65'h50);
    idle(); flush = 1; cycle();
    idle(); flush = 1; cycle();
    wr(3, 65'h3); wr(7, 65'h7);
    latch(2'b11, 3);
    @(negedge clk); #1;
    rst = 0; #1;
    chk("midreset_ready", 65'(read_ready), 65'd0);
    chk("midreset_cnt", 65'(ready_cnt), 65'd0);
    chk("midreset_cnt48", 65'(ready_cnt48), 65'd0);
    @(posedge clk); #1;
    rst = 1;
    for (int a = 0; a < 64; a++) m_rdy[a] = 0;
    m_addr[0] = 0; m_addr[1] = 0;
    wr(0, 65'h0BEE);
    for (int i = 0; i < 400; i++) begin
      idle();
      read_clkEn = 2'($urandom);
      read_addr = 12'($urandom);
      write_wen = $urandom_range(0, 1) == 1;
      write_addr = 6'($urandom);
      write_data = {$urandom, $urandom, 1'($urandom)};
      writeI_wen = $urandom_range(0, 1) == 1;
      writeI_addr = $urandom_range(0, 3) == 0 ? write_addr : 6'($urandom);
      writeI_ready = 1'($urandom);
      flush = $urandom_range(0, 15) == 0;
      cycle();
    end
    idle();
    @(negedge clk); @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iob_indir_mp.md
Name: iob_indir_mp

Overview:
- Multi-read-port indirect I/O buffer store. Each entry holds a DATA_WIDTH payload and a per-entry ready bit.
- Data writes fill the payload and set ready. Indirect writes set or clear ready without touching the payload.
- A single-cycle flush clears every ready bit.
- A registered population count of ready entries feeds the controller's issue/throttle logic in rtl/cntrl.
- Next-generation indirect buffer: N read ports, flush, ready count.

Parameters:
- ADDR_WIDTH, 6, entry index width
- ADDR_COUNT, 64, number of entries (must be ≤ 2^ADDR_WIDTH)
- DATA_WIDTH, 65, payload width
- RD_PORTS, 2, number of independent read ports (1..4)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- read_clkEn  in  RD_PORTS  per-port read address latch enable
- read_addr  in  RD_PORTS*ADDR_WIDTH  per-port read index (port p at [p*ADDR_WIDTH +: ADDR_WIDTH])
- read_data  out  RD_PORTS*DATA_WIDTH  payload of the entry at port p's latched address
- read_ready  out  RD_PORTS  ready bit of the entry at port p's latched address
- write_addr  in  ADDR_WIDTH  data write index
- write_data  in  DATA_WIDTH  data write payload
- write_wen  in  1  data write enable; writes the payload and sets ready=1
- writeI_addr  in  ADDR_WIDTH  indirect ready-write index
- writeI_ready  in  1  value written to the ready bit
- writeI_wen  in  1  indirect ready-write enable
- flush  in  1  clear all ready bits
- ready_cnt  out  ADDR_WIDTH+1  number of entries with ready=1

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous-to-clk deassert handled upstream):
  - all ready bits = 0
  - all latched read addresses = 0
  - ready_cnt = 0
  - read_ready = 0 on every port
  - payload RAM is not reset; read_data is undefined until the entry is written
- Read ports:
  - Latched address reg_p <= read_addr[p] at the edge where read_clkEn[p]=1; otherwise it holds.
  - read_data[p] = ram[reg_p] and read_ready[p] = rdy[reg_p], read combinationally from current state.
  - Effective latency: 1 cycle from address presentation.
  - A write to the entry at reg_p becomes visible on the port in the cycle after the write edge; there is no same-cycle bypass.
  - Ports are fully independent. Any number of ports may hold the same address.
- Data write: when write_wen=1, at the edge ram[write_addr] <= write_data and rdy[write_addr] <= 1.
- Indirect write: when writeI_wen=1, at the edge rdy[writeI_addr] <= writeI_ready.
- Precedence for one edge, lowest to highest:
  1. flush clears all ready bits
  2. data write sets rdy[write_addr]
  3. indirect write sets rdy[writeI_addr]
  - Consequences:
    - Same address for both writes: the writeI value wins; the payload is still written.
    - flush together with a write: the written entries end with their written ready value; all others end at 0.
- Addresses ≥ ADDR_COUNT on any write port: the write is ignored (no state change, no count change).
- Addresses ≥ ADDR_COUNT on a read port: read_ready=0 and read_data is undefined.
- ready_cnt is registered and always equals the popcount of the ready array in the same cycle.
  - It is computed from the next-state ready vector, so it never lags.
  - Range 0..ADDR_COUNT; it never wraps.
- Idempotence:
  - Setting an already-ready entry, or clearing an already-clear one, leaves ready_cnt unchanged.
  - flush with all entries clear is a no-op.
- No handshake/backpressure: every enabled write completes in the cycle issued.

Test Plan:
- Reset then read: assert rst=0 mid-operation with entries 3,7 ready → read_ready=0 on all ports and ready_cnt=0 immediately, without waiting for a clock edge; after release, latched address is 0.
- Data write then read: write_addr=5, write_data=65'h1_DEAD_BEEF_0000_0001; next cycle port0 latches addr 5 → read_data0 equals the written payload, read_ready0=1, ready_cnt=1.
- Two ports, shared address:
  - Port0 and port1 both latch addr 5, then writeI_addr=5, writeI_ready=0 → next cycle read_ready0=read_ready1=0, ready_cnt=0.
  - Payload unchanged.
- Same-address collision: write_wen and writeI_wen both on addr 9, writeI_ready=0 → rdy[9]=0, payload written, ready_cnt unchanged from before.
- Flush with concurrent write:
  - Precondition: entries 1,2,3 ready (ready_cnt=3).
  - Stimulus: flush=1 with write_addr=2 in the same cycle.
  - Required: only entry 2 ready, ready_cnt=1.
- Full / boundary:
  - Write all 64 entries → ready_cnt=64 with no wrap.
  - Repeated set of entry 63 leaves the count at 64.
  - writeI clear of entry 0 → 63.
  - Write to address ≥ ADDR_COUNT (ADDR_COUNT=48 build) is ignored.
